data_memory_bridge: RTL

Sits directly downstream of the multicycle core's memory port and turns its byte, half and word requests into word-wide accesses on a synchronous single-port RAM bank. Byte and half stores are done as read-modify-write. The block checks for misaligned and unmapped accesses, aligns and extends load data, and reports completion with a one-cycle `done` pulse. While `busy` is high the core holds its `ena` low.

---
 rtl/data_memory_bridge.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/data_memory_bridge.sv
// Bridge from the core's byte/half/word memory port to a word-wide synchronous
// single-port RAM; sub-word stores are performed as read-modify-write.
package data_memory_bridge_pkg;
    typedef enum logic [1:0] {
        MEM_ACCESS_BYTE = 2'd0,
        MEM_ACCESS_HALF = 2'd1,
        MEM_ACCESS_WORD = 2'd2
    } mem_access_t;
endpackage

module data_memory_bridge
    import data_memory_bridge_pkg::*;
#(
    parameter logic [3:0] BANK_ID = 4'h1,
    parameter int         ADDR_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [31:0]       addr,
    input  logic [31:0]       wr_data,
    input  logic              wr_ena,
    input  mem_access_t       access,
    input  logic              load_unsigned,
    output logic [31:0]       rd_data,
    output logic              done,
    output logic              busy,
    output logic [1:0]        exception,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wr_data,
    output logic              ram_wr_ena,
    input  logic [31:0]       ram_rd_data
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WRITE   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t      state_r;
    logic [1:0]  off_r;
    logic [15:0] store_lo_r;
    logic        wr_ena_r;
    mem_access_t access_r;
    logic        load_unsigned_r;
    logic [1:0]  exc_s;

    function automatic logic is_misaligned(input logic [1:0] off, input mem_access_t acc);
        case (acc)
            MEM_ACCESS_HALF: return off[0];
            MEM_ACCESS_WORD: return (off != 2'b00);
            default:         return 1'b0;
        endcase
    endfunction

    // Only the bank nibble and the bits inside the RAM's word range may be used.
    function automatic logic is_unmapped(input logic [31:0] a);
        logic [27:0] hi;
        hi = a[27:0] >> (ADDR_W + 2);
        return (a[31:28] != BANK_ID) || (hi != 28'd0);
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] off,
                                                input mem_access_t acc, input logic uns);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (acc)
            MEM_ACCESS_BYTE: return uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            MEM_ACCESS_HALF: return uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default:         return sh;
        endcase
    endfunction

    function automatic logic [31:0] merge_store(input logic [31:0] old, input logic [15:0] data,
                                                input logic [1:0] off, input mem_access_t acc);
        logic [31:0] m;
        m = old;
        if (acc == MEM_ACCESS_HALF) begin
            if (off[1]) begin
                m[31:16] = data;
            end else begin
                m[15:0] = data;
            end
        end else begin
            case (off)
                2'd0:    m[7:0]   = data[7:0];
                2'd1:    m[15:8]  = data[7:0];
                2'd2:    m[23:16] = data[7:0];
                default: m[31:24] = data[7:0];
            endcase
        end
        return m;
    endfunction

    // Exception classification of the request presented on the port.
    always_comb begin
        exc_s = 2'b00;
        exc_s = {is_unmapped(addr), is_misaligned(addr[1:0], access)};
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            off_r           <= 2'b00;
            store_lo_r      <= 16'h0000;
            wr_ena_r        <= 1'b0;
            access_r        <= MEM_ACCESS_BYTE;
            load_unsigned_r <= 1'b0;
            rd_data         <= 32'h0000_0000;
            done            <= 1'b0;
            busy            <= 1'b0;
            exception       <= 2'b00;
            ram_addr        <= '0;
            ram_wr_data     <= 32'h0000_0000;
            ram_wr_ena      <= 1'b0;
        end else begin
            done       <= 1'b0;
            ram_wr_ena <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req) begin
                        off_r           <= addr[1:0];
                        store_lo_r      <= wr_data[15:0];
                        wr_ena_r        <= wr_ena;
                        access_r        <= access;
                        load_unsigned_r <= load_unsigned;
                        exception       <= exc_s;
                        busy            <= 1'b1;
                        if (exc_s != 2'b00) begin
                            state_r <= ST_DONE;
                            done    <= 1'b1;
                        end else begin
                            ram_addr <= addr[ADDR_W+1:2];
                            if (wr_ena && (access == MEM_ACCESS_WORD)) begin
                                state_r     <= ST_WRITE;
                                ram_wr_ena  <= 1'b1;
                                ram_wr_data <= wr_data;
                            end else begin
                                state_r <= ST_RD_WAIT;
                            end
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RD_WAIT: begin
                    state_r <= ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    if (wr_ena_r) begin
                        ram_wr_data <= merge_store(ram_rd_data, store_lo_r, off_r, access_r);
                        ram_wr_ena  <= 1'b1;
                        state_r     <= ST_WRITE;
                    end else begin
                        rd_data <= extend_load(ram_rd_data, off_r, access_r, load_unsigned_r);
                        done    <= 1'b1;
                        state_r <= ST_DONE;
                    end
                end
                ST_WRITE: begin
                    done    <= 1'b1;
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
